// File: rtl/fir_tap_ctrl.sv
// -----------------------------------------------------------------------------
// fir_tap_ctrl
//
// Sequencing controller for a single-MAC, time-multiplexed FIR filter.
// Owns the circular delay line write pointer, walks all taps once per
// accepted sample, steers an external MAC and captures its result.
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   samp_in/valid/ready         input sample handshake (accepted only in IDLE)
//   coef_wr_en/addr/data        coefficient load (only honoured in IDLE)
//   busy                        high whenever the controller is not IDLE
//   dmem_we/waddr/wdata/raddr   delay-line RAM ports (1-cycle sync read)
//   cmem_we/waddr/wdata/raddr   coefficient RAM ports (1-cycle sync read)
//   mac_clr/en/last             MAC control, aligned with the RAM read data
//   acc_in                      MAC accumulator, valid the cycle after mac_last
//   y_acc/y_valid/y_ready       filter result handshake
// -----------------------------------------------------------------------------
module fir_tap_ctrl #(
    parameter int TAPS = 64,
    parameter int AW   = 6,
    parameter int DW   = 16,
    parameter int ACCW = 38
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   samp_in,
    input  logic            samp_valid,
    output logic            samp_ready,
    input  logic            coef_wr_en,
    input  logic [AW-1:0]   coef_wr_addr,
    input  logic [DW-1:0]   coef_wr_data,
    output logic            busy,
    output logic            dmem_we,
    output logic [AW-1:0]   dmem_waddr,
    output logic [DW-1:0]   dmem_wdata,
    output logic [AW-1:0]   dmem_raddr,
    output logic            cmem_we,
    output logic [AW-1:0]   cmem_waddr,
    output logic [DW-1:0]   cmem_wdata,
    output logic [AW-1:0]   cmem_raddr,
    output logic            mac_clr,
    output logic            mac_en,
    output logic            mac_last,
    input  logic [ACCW-1:0] acc_in,
    output logic [ACCW-1:0] y_acc,
    output logic            y_valid,
    input  logic            y_ready
);

    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_IDLE    = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_CAPTURE = 3'd4,
        S_OUT     = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_W   = (AW + 1)'(TAPS);

    state_t            state_q,     state_d;
    logic [AW-1:0]     clr_idx_q,   clr_idx_d;
    logic [AW-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]     newest_q,    newest_d;
    logic [AW-1:0]     k_q,         k_d;
    logic [ACCW-1:0]   y_acc_q,     y_acc_d;
    logic              y_valid_q,   y_valid_d;
    logic              mac_clr_q,   mac_clr_d;
    logic              mac_en_q,    mac_en_d;
    logic              mac_last_q,  mac_last_d;
    logic [AW:0]       rdiff_s;

    // Increment an index modulo TAPS (TAPS need not be a power of two).
    function automatic logic [AW-1:0] inc_wrap(input logic [AW-1:0] v);
        if (v == LAST_IDX) begin
            return {AW{1'b0}};
        end else begin
            return v + AW'(1);
        end
    endfunction

    // Delay-line read address: newest sample minus tap index, modulo TAPS.
    always_comb begin
        rdiff_s = {1'b0, newest_q} - {1'b0, k_q};
        if (rdiff_s[AW]) begin
            dmem_raddr = AW'(rdiff_s + TAPS_W);
        end else begin
            dmem_raddr = rdiff_s[AW-1:0];
        end
    end

    assign cmem_raddr = k_q;
    assign busy       = (state_q != S_IDLE);
    assign y_acc      = y_acc_q;
    assign y_valid    = y_valid_q;
    assign mac_clr    = mac_clr_q;
    assign mac_en     = mac_en_q;
    assign mac_last   = mac_last_q;

    // Next-state logic and combinational RAM/handshake outputs.
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        wr_ptr_d   = wr_ptr_q;
        newest_d   = newest_q;
        k_d        = k_q;
        y_acc_d    = y_acc_q;
        y_valid_d  = y_valid_q;
        mac_clr_d  = 1'b0;
        mac_en_d   = 1'b0;
        mac_last_d = 1'b0;
        samp_ready = 1'b0;
        dmem_we    = 1'b0;
        dmem_waddr = wr_ptr_q;
        dmem_wdata = {DW{1'b0}};
        cmem_we    = 1'b0;
        cmem_waddr = coef_wr_addr;
        cmem_wdata = coef_wr_data;

        case (state_q)
            S_CLEAR: begin
                // Zero one delay-line entry per cycle so stale history never leaks.
                dmem_we    = 1'b1;
                dmem_waddr = clr_idx_q;
                if (clr_idx_q == LAST_IDX) begin
                    clr_idx_d = {AW{1'b0}};
                    state_d   = S_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + AW'(1);
                end
            end
            S_IDLE: begin
                // A coefficient write takes priority over a sample that cycle.
                if (coef_wr_en) begin
                    cmem_we = 1'b1;
                end else begin
                    samp_ready = 1'b1;
                    if (samp_valid) begin
                        dmem_we    = 1'b1;
                        dmem_wdata = samp_in;
                        newest_d   = wr_ptr_q;
                        wr_ptr_d   = inc_wrap(wr_ptr_q);
                        k_d        = {AW{1'b0}};
                        state_d    = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                // MAC controls are delayed one cycle to line up with RAM read data.
                mac_en_d   = 1'b1;
                mac_clr_d  = (k_q == {AW{1'b0}});
                mac_last_d = (k_q == LAST_IDX);
                if (k_q == LAST_IDX) begin
                    k_d     = {AW{1'b0}};
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                y_acc_d   = acc_in;
                y_valid_d = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (y_ready) begin
                    y_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                clr_idx_d = {AW{1'b0}};
                state_d   = S_CLEAR;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_CLEAR;
            clr_idx_q  <= {AW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            newest_q   <= {AW{1'b0}};
            k_q        <= {AW{1'b0}};
            y_acc_q    <= {ACCW{1'b0}};
            y_valid_q  <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            mac_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            newest_q   <= newest_d;
            k_q        <= k_d;
            y_acc_q    <= y_acc_d;
            y_valid_q  <= y_valid_d;
            mac_clr_q  <= mac_clr_d;
            mac_en_q   <= mac_en_d;
            mac_last_q <= mac_last_d;
        end
    end

endmodule

// File: tb/tb_fir_tap_ctrl.sv
// Self-checking bench for fir_tap_ctrl: behavioural RAMs and MAC around the
// DUT, results compared against a direct convolution over the sample history.
module tb_fir_tap_ctrl;

    localparam int TAPS = 64;
    localparam int AW   = 6;
    localparam int DW   = 16;
    localparam int ACCW = 38;

    logic            clk = 1'b0;
    logic            reset;
    logic [DW-1:0]   samp_in;
    logic            samp_valid;
    logic            samp_ready;
    logic            coef_wr_en;
    logic [AW-1:0]   coef_wr_addr;
    logic [DW-1:0]   coef_wr_data;
    logic            busy;
    logic            dmem_we;
    logic [AW-1:0]   dmem_waddr;
    logic [DW-1:0]   dmem_wdata;
    logic [AW-1:0]   dmem_raddr;
    logic            cmem_we;
    logic [AW-1:0]   cmem_waddr;
    logic [DW-1:0]   cmem_wdata;
    logic [AW-1:0]   cmem_raddr;
    logic            mac_clr;
    logic            mac_en;
    logic            mac_last;
    logic [ACCW-1:0] acc_in;
    logic [ACCW-1:0] y_acc;
    logic            y_valid;
    logic            y_ready;

    int n_vec = 0;
    int n_err = 0;

    fir_tap_ctrl #(.TAPS(TAPS), .AW(AW), .DW(DW), .ACCW(ACCW)) dut (
        .clk(clk), .reset(reset),
        .samp_in(samp_in), .samp_valid(samp_valid), .samp_ready(samp_ready),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .busy(busy),
        .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_raddr(dmem_raddr),
        .cmem_we(cmem_we), .cmem_waddr(cmem_waddr), .cmem_wdata(cmem_wdata), .cmem_raddr(cmem_raddr),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last),
        .acc_in(acc_in), .y_acc(y_acc), .y_valid(y_valid), .y_ready(y_ready)
    );

    always #5 clk = ~clk;

    // Behavioural RAMs (1-cycle synchronous read) and MAC.
    logic [DW-1:0]          dmem_m [TAPS];
    logic [DW-1:0]          cmem_m [TAPS];
    logic [DW-1:0]          drd, crd;
    logic signed [31:0]     prod_s;
    logic signed [ACCW-1:0] prod_x;
    logic [ACCW-1:0]        acc_m;

    assign prod_s = $signed(drd) * $signed(crd);
    assign prod_x = prod_s;
    assign acc_in = acc_m;

    always @(posedge clk) begin
        if (dmem_we) dmem_m[dmem_waddr] <= dmem_wdata;
        if (cmem_we) cmem_m[cmem_waddr] <= cmem_wdata;
        drd <= dmem_m[dmem_raddr];
        crd <= cmem_m[cmem_raddr];
        if (mac_clr) acc_m <= prod_x;
        else if (mac_en) acc_m <= acc_m + prod_x;
    end

    // Reference: coefficient table plus sample history, newest first.
    logic [DW-1:0] ref_coef [TAPS];
    logic [DW-1:0] hist [$];
    int            m_wr_ptr;

    function automatic logic [ACCW-1:0] ref_y();
        longint s = 0;
        for (int k = 0; k < TAPS; k++)
            s += longint'($signed(hist[k])) * longint'($signed(ref_coef[k]));
        return s[ACCW-1:0];
    endfunction

    task automatic reset_model();
        hist.delete();
        for (int i = 0; i < TAPS; i++) hist.push_back('0);
        m_wr_ptr = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a reset edge: walk the clear sequence.
    task automatic check_clear();
        int n = 0;
        int werr = 0;
        while (n < 200) begin
            if (samp_ready) break;
            if (!dmem_we || dmem_waddr != AW'(n % TAPS) || dmem_wdata != '0 ||
                y_valid || mac_en || mac_clr || mac_last || cmem_we || !busy)
                werr++;
            tick();
            n++;
        end
        check("clear_len", n, 64);
        check("clear_writes", werr, 0);
        check("clear_busy_after", busy, 0);
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        while (!samp_ready && n < 200) begin tick(); n++; end
        coef_wr_en = 1'b1; coef_wr_addr = a; coef_wr_data = d;
        #1;
        check("coef_we", cmem_we, 1);
        check("coef_blocks_ready", samp_ready, 0);
        ref_coef[a] = d;
        tick();
        coef_wr_en = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] s, input int hold, input bit collide,
                        input int abort_k, output logic [ACCW-1:0] y);
        int n, c, yv, en_cnt, first_en, clr_c, last_c, rerr, serr, newest;
        logic [ACCW-1:0] e, y0;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        y = '0;
        n = 0;
        while (!samp_ready && n < 200) begin tick(); n++; end
        check("ready_wait", n < 200, 1);
        samp_valid = 1'b1; samp_in = s;
        if (collide) begin
            ca = AW'($urandom_range(0, TAPS - 1)); cd = DW'($urandom);
            coef_wr_en = 1'b1; coef_wr_addr = ca; coef_wr_data = cd;
            #1;
            check("collide_ready", samp_ready, 0);
            check("collide_cmem_we", cmem_we, 1);
            check("collide_dmem_we", dmem_we, 0);
            ref_coef[ca] = cd;
            tick();
            coef_wr_en = 1'b0;
        end
        #1;
        check("accept_ready", samp_ready, 1);
        check("accept_dmem_we", dmem_we, 1);
        check("accept_wr_ptr", dmem_waddr, m_wr_ptr);
        newest = m_wr_ptr;
        hist.push_front(s);
        void'(hist.pop_back());
        m_wr_ptr = (m_wr_ptr + 1) % TAPS;
        e = ref_y();
        tick();
        samp_valid = 1'b0;
        c = 1; yv = -1; en_cnt = 0; first_en = -1; clr_c = -1; last_c = -1; rerr = 0;
        while (c < 200) begin
            if (abort_k >= 0 && c == abort_k + 1) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                reset_model();
                check_clear();
                return;
            end
            if (mac_en) begin en_cnt++; if (first_en < 0) first_en = c; end
            if (mac_clr) clr_c = c;
            if (mac_last) last_c = c;
            if (c <= TAPS) begin
                if (dmem_raddr != AW'(((newest - (c - 1)) % TAPS + TAPS) % TAPS)) rerr++;
                if (cmem_raddr != AW'(c - 1)) rerr++;
                if (!busy || dmem_we || cmem_we) rerr++;
            end
            if (c == 10) begin
                coef_wr_en = 1'b1; coef_wr_addr = AW'($urandom); coef_wr_data = DW'($urandom);
                #1;
                check("run_coef_ignored", cmem_we, 0);
                check("run_not_ready", samp_ready, 0);
                coef_wr_en = 1'b0;
            end
            if (y_valid) begin yv = c; break; end
            tick();
            c++;
        end
        check("latency", yv, 67);
        check("mac_en_count", en_cnt, 64);
        check("mac_en_first", first_en, 2);
        check("mac_clr_cycle", clr_c, 2);
        check("mac_last_cycle", last_c, 65);
        check("read_addr_seq", rerr, 0);
        check("y_acc", y_acc, e);
        y = y_acc;
        y0 = y_acc;
        serr = 0;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (!y_valid || y_acc != y0 || samp_ready || !busy) serr++;
        end
        check("out_hold", serr, 0);
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
        #1;
        check("back_idle", {busy, y_valid, samp_ready}, 3'b001);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [ACCW-1:0] y;
        logic [DW-1:0] s;
        reset = 1'b1; samp_in = '0; samp_valid = 1'b0; coef_wr_en = 1'b0;
        coef_wr_addr = '0; coef_wr_data = '0; y_ready = 1'b0;
        reset_model();
        repeat (3) tick();
        check("reset_state", {y_valid, mac_en, mac_clr, mac_last, samp_ready, busy}, 6'b000001);
        reset = 1'b0;
        check_clear();

        // Impulse response with coef[i] = i+1.
        for (int i = 0; i < TAPS; i++) write_coef(AW'(i), DW'(i + 1));
        for (int n = 0; n < TAPS; n++) begin
            send((n == 0) ? DW'(1) : DW'(0), 0, 1'b0, -1, y);
            check("impulse", y, n + 1);
        end

        // Long hold in OUT, then a coefficient/sample collision.
        send(16'h1234, 10, 1'b0, -1, y);
        send(16'h0F0F, 0, 1'b1, -1, y);

        // Random coefficients and samples, including full-scale values.
        for (int i = 0; i < TAPS; i++) write_coef(AW'(i), DW'($urandom));
        write_coef(6'd0, 16'h8000);
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 3))
                0:       s = 16'h8000;
                1:       s = 16'h7FFF;
                default: s = DW'($urandom);
            endcase
            send(s, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), -1, y);
        end

        // Abort mid-computation at tap 30, then resume from a cleared line.
        send(16'h4321, 0, 1'b0, 30, y);
        for (int n = 0; n < 3; n++) send(DW'($urandom), 1, 1'b0, -1, y);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
